t1_event_log_arbiter: RTL
=========================

Name: t1_event_log_arbiter

Overview:
- Shares the single RTL event-log sink between NUM_SRC event producers (lanes, LSU, issue, retire monitors).
- Output is one serialized, cycle-stamped event per handshake.
- Round-robin fairness; one-entry output register.
- Quit sequencing lets simulation control drain all pending events before the log is closed and the sim finishes.

Parameters:
- NUM_SRC, 4, number of requesting event producers (2..16).
- PAYLOAD_W, 64, event payload width in bits.
- CYC_W, 64, width of the free-running cycle stamp.
- STARVE_LIMIT, 1024, max cycles a valid source may wait; used only with the optional feature.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_SRC  per-source event valid.
- req_ready  out  NUM_SRC  per-source accept, one-hot or zero.
- req_data  in  NUM_SRC*PAYLOAD_W  per-source payload; source i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- log_valid  out  1  event available to the sink.
- log_ready  in  1  sink accepts the event.
- log_src  out  $clog2(NUM_SRC)  originating source index.
- log_data  out  PAYLOAD_W  payload.
- log_cycle  out  CYC_W  cycle on which the source handshake occurred.
- quit_req  in  1  level; simulation control requests drain.
- drained  out  1  high in DONE state.
- starve_err  out  1  sticky starvation flag; optional feature.
- starve_src  out  $clog2(NUM_SRC)  first starving source; optional feature.

Behaviour:
- Reset values:
  - Outputs: log_valid=0, log_src=0, log_data=0, log_cycle=0, req_ready=0, drained=0, starve_err=0, starve_src=0.
  - Internal: cycle counter=0, rr_ptr=0, state=RUN.
- Cycle counter:
  - Increments every clock after reset deasserts.
  - Wraps modulo 2^CYC_W with no flag.
- can_accept = !log_valid || log_ready.
- Arbitration:
  - Grant the first valid source at or after rr_ptr, searching cyclically.
  - req_ready[g]=1 only when can_accept and state != DONE.
  - req_ready is combinational from req_valid, log_valid, log_ready and state.
  - On a source handshake, rr_ptr <= (g+1) mod NUM_SRC. With NUM_SRC=3, g=2 wraps to 0.
  - If no handshake occurs, rr_ptr holds.
- Latency:
  - A source handshake on cycle N loads the output register with src, data and cycle=N.
  - log_valid is asserted on cycle N+1.
  - Back-to-back throughput is 1 event/cycle while log_ready=1.
- Sink backpressure:
  - While log_valid && !log_ready, all output fields are held stable and req_ready=0.
  - A sink handshake and a new source handshake in the same cycle replace the entry with no bubble.
- States:
  - RUN: normal operation. quit_req=1 -> DRAIN.
  - DRAIN: still accepts events. Go to DONE when no req_valid bit is set and either log_valid=0 or (log_valid && log_ready) with no new grant in that cycle.
  - DONE: req_ready=0; drained=1 from the cycle after entry. Stays in DONE until reset; quit_req deassertion is ignored.
- quit_req rising in the same cycle as a handshake: the handshake completes and the state becomes DRAIN.
- Reset mid-operation: the held output event is discarded, and the state and all counters return to reset values asynchronously.

Optional Feature:
- Macro: T1_EVENT_LOG_STARVE_CHECK_EN.
- Defined:
  - Per-source wait counter: increments while req_valid[i] && !req_ready[i]; clears on handshake or when req_valid[i]=0.
  - When a counter reaches STARVE_LIMIT, starve_err is set (sticky until reset).
  - starve_src latches the lowest such index on the first occurrence only.
  - Simulation-only $error message names the source.
- Undefined: starve_err and starve_src are tied to 0; no counters are built.

Decomposition:
- Package t1_event_log_pkg holds:
  - state enum {RUN, DRAIN, DONE};
  - cycle-stamp typedef;
  - log record struct {src, cycle, data}, parameterized through localparams.
- Sub-module t1_rr_pick: combinational round-robin picker, inputs req vector and ptr, outputs one-hot grant, index and any.

Test Plan:
- Reset at cycle 0, then req_valid=4'b1111, log_ready=1 -> log_src sequence 0,1,2,3,0 on consecutive cycles; log_cycle values increase by 1.
- rr_ptr=2, req_valid=4'b0011 -> grant src0 (wrap); next grant src1.
- log_ready=0 for 5 cycles with log_valid=1 -> log_data/src/cycle unchanged and req_ready=0 throughout; log_ready=1 -> the next event follows on the very next cycle.
- quit_req=1 with src3 holding 3 pending events and log_ready=1 -> all 3 events are logged, then drained=1; a later req_valid sees req_ready=0.
- reset asserted mid-stall with log_valid=1 -> log_valid=0 immediately (asynchronous); after release the cycle stamp restarts at 0.
- With T1_EVENT_LOG_STARVE_CHECK_EN, STARVE_LIMIT=8: hold log_ready=0 for 10 cycles with src1 valid -> starve_err=1, starve_src=1, both sticky.

Source files
------------

// File: rtl/t1_event_log_pkg.sv
// ============================================================================
//  Module   : t1_event_log_pkg
//  Brief    : Shared types for the event-log arbiter (state, cycle stamp, record).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package t1_event_log_pkg;

    localparam int c_rec_src_w  = 4;
    localparam int c_rec_cyc_w  = 64;
    localparam int c_rec_data_w = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [c_rec_cyc_w-1:0] cyc_t;

    typedef struct packed {
        logic [c_rec_src_w-1:0]  src;
        cyc_t                    cycle;
        logic [c_rec_data_w-1:0] data;
    } log_rec_t;

endpackage

`default_nettype wire

// File: rtl/t1_rr_pick.sv
// ============================================================================
//  Module   : t1_rr_pick
//  Brief    : Combinational round-robin picker; first requester at or after ptr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module t1_rr_pick
    import t1_event_log_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int w_pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_pos = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_pos = (int'(ptr) + k) % NUM_SRC;
            if (!any && req[w_pos[IDX_W-1:0]]) begin
                any                     = 1'b1;
                idx                     = w_pos[IDX_W-1:0];
                grant[w_pos[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/t1_event_log_arbiter.sv
// ============================================================================
//  Module   : t1_event_log_arbiter
//  Brief    : Round-robin arbiter serializing cycle-stamped events into one log
//             sink, with quit/drain sequencing. Optional starvation checker
//             enabled by T1_EVENT_LOG_STARVE_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module t1_event_log_arbiter
    import t1_event_log_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int PAYLOAD_W    = 64,
    parameter int CYC_W        = 64,
    parameter int STARVE_LIMIT = 1024,
    parameter int SRC_W        = $clog2(NUM_SRC)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           req_valid,
    output logic [NUM_SRC-1:0]           req_ready,
    input  logic [NUM_SRC*PAYLOAD_W-1:0] req_data,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [SRC_W-1:0]             log_src,
    output logic [PAYLOAD_W-1:0]         log_data,
    output logic [CYC_W-1:0]             log_cycle,
    input  logic                         quit_req,
    output logic                         drained,
    output logic                         starve_err,
    output logic [SRC_W-1:0]             starve_src
);

    state_t                 r_state, w_state_nxt;
    logic [CYC_W-1:0]       r_cycle;
    logic [SRC_W-1:0]       r_rr_ptr;
    logic                   r_log_valid;
    logic [SRC_W-1:0]       r_log_src;
    logic [PAYLOAD_W-1:0]   r_log_data;
    logic [CYC_W-1:0]       r_log_cycle;

    logic [NUM_SRC-1:0]     w_grant;
    logic [SRC_W-1:0]       w_idx;
    logic [SRC_W-1:0]       w_ptr_nxt;
    logic                   w_any;
    logic                   w_can_accept;
    logic                   w_accept_en;
    logic                   w_src_hs;
    logic [PAYLOAD_W-1:0]   w_sel_data;

    t1_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (SRC_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_can_accept = !r_log_valid || log_ready;
    assign w_accept_en  = w_can_accept && (r_state != ST_DONE);
    assign w_src_hs     = w_accept_en && w_any;
    assign req_ready    = w_accept_en ? w_grant : '0;
    // Explicit wrap so non-power-of-two source counts return to 0.
    assign w_ptr_nxt    = (w_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_idx == SRC_W'(i)) begin
                w_sel_data = req_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_log_valid <= 1'b0;
            r_log_src   <= '0;
            r_log_data  <= '0;
            r_log_cycle <= '0;
            r_rr_ptr    <= '0;
        end else if (w_src_hs) begin
            r_log_valid <= 1'b1;
            r_log_src   <= w_idx;
            r_log_data  <= w_sel_data;
            r_log_cycle <= r_cycle;
            r_rr_ptr    <= w_ptr_nxt;
        end else if (log_ready) begin
            r_log_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (quit_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Close only once nothing is pending upstream and the held entry leaves.
                if ((req_valid == '0) && (!r_log_valid || (log_ready && !w_src_hs))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign drained   = (r_state == ST_DONE);
    assign log_valid = r_log_valid;
    assign log_src   = r_log_src;
    assign log_data  = r_log_data;
    assign log_cycle = r_log_cycle;

`ifdef T1_EVENT_LOG_STARVE_CHECK_EN
    localparam int c_wait_w = $clog2(STARVE_LIMIT + 1);

    logic [NUM_SRC-1:0] w_at_limit;
    logic               w_any_limit;
    logic [SRC_W-1:0]   w_first_limit;
    logic               r_starve_err;
    logic [SRC_W-1:0]   r_starve_src;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_wait
        logic [c_wait_w-1:0] r_wait;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_wait <= '0;
            end else if (!req_valid[i] || req_ready[i]) begin
                r_wait <= '0;
            end else if (!w_at_limit[i]) begin
                r_wait <= r_wait + 1'b1;
            end
        end

        assign w_at_limit[i] = (r_wait == c_wait_w'(STARVE_LIMIT));
    end

    always_comb begin
        w_any_limit   = 1'b0;
        w_first_limit = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_at_limit[i]) begin
                w_any_limit   = 1'b1;
                w_first_limit = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve_err <= 1'b0;
            r_starve_src <= '0;
        end else if (w_any_limit && !r_starve_err) begin
            r_starve_err <= 1'b1;
            r_starve_src <= w_first_limit;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset && w_any_limit && !r_starve_err) begin
            $error("t1_event_log_arbiter: source %0d starved for %0d cycles", w_first_limit, STARVE_LIMIT);
        end
    end
`endif

    assign starve_err = r_starve_err;
    assign starve_src = r_starve_src;
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
    assign starve_err        = 1'b0;
    assign starve_src        = '0;
`endif

endmodule

`default_nettype wire
